// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bus around uart_tx_arbiter: byte lanes in, one FIFO write port out.
// Handshake: a lane byte moves only on a cycle where req_valid[i] and req_ready[i] are both high;
// ready may be high without valid. tx_wr_en is never high while tx_full is high.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_full;
  logic                 tx_wr_en;
  logic [7:0]           tx_din;
  logic                 grant_valid;
  logic [2:0]           grant_id;
  logic [2:0]           fsm_state;

  modport slave (
    input  req_valid, req_data, req_last, tx_full,
    output req_ready, tx_wr_en, tx_din, grant_valid, grant_id, fsm_state
  );

  modport master (
    output req_valid, req_data, req_last, tx_full,
    input  req_ready, tx_wr_en, tx_din, grant_valid, grant_id, fsm_state
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one transmitter FIFO write port between
// NUM_REQ byte-stream requesters, with an optional channel tag byte ahead of each packet.
module uart_tx_arbiter #(
  parameter int         NUM_REQ  = 4,
  parameter bit         TAG_EN   = 1'b1,
  parameter logic [7:0] TAG_BASE = 8'hF0
) (
  input  logic            clk,
  input  logic            srst,
  uart_tx_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    TAG  = 3'b010,
    DATA = 3'b100
  } state_t;

  state_t             state, state_nxt;
  logic [2:0]         grant_id_q;
  logic [2:0]         last_grant;
  logic [2:0]         pick;
  logic               any_valid;
  logic               sel_valid;
  logic               sel_last;
  logic [7:0]         sel_data;
  logic [NUM_REQ-1:0] ready;
  logic               wr_en;
  logic [7:0]         din;

  assign any_valid = |bus.req_valid;

  // Search order starts at last_grant+1 and wraps; iterating k downward lets the
  // nearest requester overwrite farther ones.
  always_comb begin
    pick = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (bus.req_valid[j] &&
            ((int'(last_grant) + k == j) || (int'(last_grant) + k == j + NUM_REQ))) begin
          pick = 3'(j);
        end
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = 8'h00;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant_id_q == 3'(j)) begin
        sel_valid = bus.req_valid[j];
        sel_last  = bus.req_last[j];
        sel_data  = bus.req_data[8*j +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state      <= IDLE;
      last_grant <= 3'(NUM_REQ - 1);
      grant_id_q <= 3'b000;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_valid) begin
        grant_id_q <= pick;
        last_grant <= pick;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = '0;
    wr_en     = 1'b0;
    din       = 8'h00;
    case (state)
      IDLE: begin
        if (any_valid) state_nxt = TAG_EN ? TAG : DATA;
      end
      TAG: begin
        // The tag goes out even if the granted requester has meanwhile dropped valid.
        din   = TAG_BASE + {5'b00000, grant_id_q};
        wr_en = !bus.tx_full;
        if (!bus.tx_full) state_nxt = DATA;
      end
      DATA: begin
        din = sel_data;
        for (int j = 0; j < NUM_REQ; j++) begin
          ready[j] = (grant_id_q == 3'(j)) && !bus.tx_full;
        end
        wr_en = sel_valid && !bus.tx_full;
        if (wr_en && sel_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.req_ready   = ready;
  assign bus.tx_wr_en    = wr_en;
  assign bus.tx_din      = din;
  assign bus.grant_valid = (state != IDLE);
  assign bus.grant_id    = grant_id_q;
  assign bus.fsm_state   = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed vector table, hand sequences for stalls, valid gaps and
// mid-packet reset, a TAG_EN=0 instance, and random traffic against a packet-level model.
module tb_uart_tx_arbiter;
  localparam int         N  = 4;
  localparam logic [7:0] TB = 8'hF0;

  logic clk = 1'b0;
  logic srst, srst0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();
  uart_tx_arbiter_if #(.NUM_REQ(N)) bus0 ();

  uart_tx_arbiter #(.NUM_REQ(N), .TAG_EN(1'b1), .TAG_BASE(TB)) dut (
    .clk(clk), .srst(srst), .bus(bus)
  );
  uart_tx_arbiter #(.NUM_REQ(N), .TAG_EN(1'b0), .TAG_BASE(TB)) dut0 (
    .clk(clk), .srst(srst0), .bus(bus0)
  );

  typedef struct {
    logic [N-1:0]   v;
    logic [8*N-1:0] d;
    logic [N-1:0]   l;
    logic           full;
    logic           e_wr;
    logic [7:0]     e_din;
    logic [N-1:0]   e_rdy;
    logic           e_gv;
    logic [2:0]     e_gid;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  // Per-requester pending bytes {last, data}; exp_q is the expected FIFO byte stream.
  logic [8:0] byte_q [N][$];
  logic [7:0] exp_q[$];
  logic [7:0] tag_log[$];

  // Packet-level model: current owner (-1 when none), whether its tag is still owed,
  // and the most recently granted requester.
  int m_owner;
  int m_last;
  bit m_tag;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_tag   = 1'b0;
  endtask

  task automatic clear_queues();
    for (int i = 0; i < N; i++) byte_q[i].delete();
    exp_q.delete();
    tag_log.delete();
  endtask

  task automatic do_reset();
    srst          = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.tx_full   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    srst = 1'b0;
    model_reset();
    clear_queues();
  endtask

  task automatic add_packet(input int req, input int len, input logic [7:0] first, input bit rnd);
    logic [7:0] b;
    for (int k = 0; k < len; k++) begin
      b = rnd ? 8'($urandom_range(0, 255)) : first + 8'(k);
      byte_q[req].push_back({(k == len - 1), b});
    end
  endtask

  // One clock: drive lane heads, check outputs against the model, then advance the model.
  task automatic tick(input logic rst, input logic full, input logic [N-1:0] vmask);
    logic [N-1:0]   v, lst, e_rdy;
    logic [8*N-1:0] d;
    logic           e_wr, e_gv;
    logic [7:0]     e_din;
    int             pick;
    for (int i = 0; i < N; i++) begin
      if (byte_q[i].size() > 0) begin
        v[i]         = vmask[i];
        d[8*i +: 8]  = byte_q[i][0][7:0];
        lst[i]       = byte_q[i][0][8];
      end else begin
        v[i]         = 1'b0;
        d[8*i +: 8]  = 8'h00;
        lst[i]       = 1'b0;
      end
    end
    srst          = rst;
    bus.req_valid = v;
    bus.req_data  = d;
    bus.req_last  = lst;
    bus.tx_full   = full;
    #1;
    e_rdy = '0;
    if (m_owner < 0) begin
      e_wr = 1'b0; e_gv = 1'b0; e_din = 8'h00;
    end else if (m_tag) begin
      e_wr = !full; e_gv = 1'b1; e_din = TB + 8'(m_owner);
    end else begin
      e_gv  = 1'b1;
      e_din = d[8*m_owner +: 8];
      e_wr  = v[m_owner] && !full;
      if (!full) e_rdy[m_owner] = 1'b1;
    end
    check("wr_en", 32'(bus.tx_wr_en), 32'(e_wr));
    check("req_ready", 32'(bus.req_ready), 32'(e_rdy));
    check("grant_valid", 32'(bus.grant_valid), 32'(e_gv));
    check("tx_din", 32'(bus.tx_din), 32'(e_din));
    if (e_gv) check("grant_id", 32'(bus.grant_id), 32'(m_owner));
    if (bus.tx_wr_en && exp_q.size() > 0) check("stream", 32'(bus.tx_din), 32'(exp_q.pop_front()));
    if (bus.tx_wr_en && bus.tx_din >= TB) tag_log.push_back(bus.tx_din);
    for (int i = 0; i < N; i++) begin
      if (v[i] && e_rdy[i]) void'(byte_q[i].pop_front());
    end
    if (rst) begin
      model_reset();
    end else if (m_owner < 0) begin
      pick = -1;
      for (int k = 1; k <= N; k++) begin
        if (pick < 0 && v[(m_last + k) % N]) pick = (m_last + k) % N;
      end
      if (pick >= 0) begin
        m_owner = pick;
        m_last  = pick;
        m_tag   = 1'b1;
      end
    end else if (m_tag) begin
      if (!full) m_tag = 1'b0;
    end else if (e_wr && lst[m_owner]) begin
      m_owner = -1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input logic [N-1:0] mask, input int p_valid, input int p_full,
                       input int budget, input string name);
    int         cyc;
    bit         busy;
    logic [N-1:0] vm;
    cyc = 0;
    busy = 1'b1;
    while (busy) begin
      busy = (m_owner >= 0);
      for (int i = 0; i < N; i++) if (byte_q[i].size() > 0) busy = 1'b1;
      if (busy && cyc >= budget) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, cyc);
        busy = 1'b0;
      end else if (busy) begin
        for (int i = 0; i < N; i++) vm[i] = mask[i] && ($urandom_range(0, 99) < p_valid);
        tick(1'b0, ($urandom_range(0, 99) < p_full), vm);
        cyc++;
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[13];
    logic [7:0] exp_tags[5];
    int         nwr;

    srst0          = 1'b1;
    bus0.req_valid = '0;
    bus0.req_data  = '0;
    bus0.req_last  = '0;
    bus0.tx_full   = 1'b0;
    srst           = 1'b1;
    @(negedge clk);

    // Directed table: req0 sends 11,22,33, then req2 single byte AB with full stalls.
    tbl[0]  = '{4'b0001, 32'h00000011, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 3'd0};
    tbl[1]  = '{4'b0001, 32'h00000011, 4'b0000, 1'b0, 1'b1, 8'hF0, 4'b0000, 1'b1, 3'd0};
    tbl[2]  = '{4'b0001, 32'h00000011, 4'b0000, 1'b0, 1'b1, 8'h11, 4'b0001, 1'b1, 3'd0};
    tbl[3]  = '{4'b0001, 32'h00000022, 4'b0000, 1'b0, 1'b1, 8'h22, 4'b0001, 1'b1, 3'd0};
    tbl[4]  = '{4'b0001, 32'h00000033, 4'b0001, 1'b0, 1'b1, 8'h33, 4'b0001, 1'b1, 3'd0};
    tbl[5]  = '{4'b0000, 32'h00000000, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 3'd0};
    tbl[6]  = '{4'b0100, 32'h00AB0000, 4'b0100, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 3'd0};
    tbl[7]  = '{4'b0100, 32'h00AB0000, 4'b0100, 1'b1, 1'b0, 8'hF2, 4'b0000, 1'b1, 3'd2};
    tbl[8]  = '{4'b0100, 32'h00AB0000, 4'b0100, 1'b0, 1'b1, 8'hF2, 4'b0000, 1'b1, 3'd2};
    tbl[9]  = '{4'b0000, 32'h00AB0000, 4'b0100, 1'b0, 1'b0, 8'hAB, 4'b0100, 1'b1, 3'd2};
    tbl[10] = '{4'b0100, 32'h00AB0000, 4'b0100, 1'b1, 1'b0, 8'hAB, 4'b0000, 1'b1, 3'd2};
    tbl[11] = '{4'b0100, 32'h00AB0000, 4'b0100, 1'b0, 1'b1, 8'hAB, 4'b0100, 1'b1, 3'd2};
    tbl[12] = '{4'b0000, 32'h00000000, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 3'd2};

    do_reset();
    for (int r = 0; r < 13; r++) begin
      bus.req_valid = tbl[r].v;
      bus.req_data  = tbl[r].d;
      bus.req_last  = tbl[r].l;
      bus.tx_full   = tbl[r].full;
      #1;
      check($sformatf("tbl%0d_wr", r), 32'(bus.tx_wr_en), 32'(tbl[r].e_wr));
      check($sformatf("tbl%0d_din", r), 32'(bus.tx_din), 32'(tbl[r].e_din));
      check($sformatf("tbl%0d_rdy", r), 32'(bus.req_ready), 32'(tbl[r].e_rdy));
      check($sformatf("tbl%0d_gv", r), 32'(bus.grant_valid), 32'(tbl[r].e_gv));
      check($sformatf("tbl%0d_gid", r), 32'(bus.grant_id), 32'(tbl[r].e_gid));
      @(posedge clk);
      @(negedge clk);
    end

    // Fairness: all requesters hold 2-byte packets.
    do_reset();
    for (int i = 0; i < N; i++) begin
      add_packet(i, 2, 8'(16 * i), 1'b0);
      add_packet(i, 2, 8'(16 * i + 8), 1'b0);
    end
    drain(4'b1111, 100, 0, 200, "t2");
    exp_tags = '{8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'hF0};
    check("t2_ntags", 32'(tag_log.size()), 32'd8);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t2_tag%0d", k),
            32'((k < tag_log.size()) ? tag_log[k] : 8'h00), 32'(exp_tags[k]));
    end

    // Five full cycles mid-DATA on req2; stream must resume without loss or duplication.
    do_reset();
    add_packet(2, 6, 8'h20, 1'b0);
    exp_q.push_back(8'hF2);
    for (int k = 0; k < 6; k++) exp_q.push_back(8'h20 + 8'(k));
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 4'b0100);
    for (int k = 0; k < 5; k++) tick(1'b0, 1'b1, 4'b0100);
    drain(4'b0100, 100, 0, 50, "t3");
    check("t3_stream_left", 32'(exp_q.size()), 32'd0);
    check("t3_bytes_left", 32'(byte_q[2].size()), 32'd0);

    // req1 pauses for 10 cycles mid-packet while req3 waits.
    do_reset();
    add_packet(1, 4, 8'h40, 1'b0);
    add_packet(3, 2, 8'h50, 1'b0);
    for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, 4'b1010);
    for (int k = 0; k < 10; k++) tick(1'b0, 1'b0, 4'b1000);
    check("t4_grant_held", 32'(bus.grant_id), 32'd1);
    drain(4'b1010, 100, 0, 50, "t4");
    check("t4_ntags", 32'(tag_log.size()), 32'd2);
    check("t4_first", 32'((tag_log.size() > 0) ? tag_log[0] : 8'h00), 32'hF1);
    check("t4_second", 32'((tag_log.size() > 1) ? tag_log[1] : 8'h00), 32'hF3);

    // Reset during req2 DATA, then simultaneous req0/req2.
    do_reset();
    add_packet(2, 5, 8'h60, 1'b0);
    for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, 4'b0100);
    tick(1'b1, 1'b0, 4'b0100);
    clear_queues();
    tick(1'b0, 1'b0, 4'b0000);
    check("t5_gid_after_rst", 32'(bus.grant_id), 32'd0);
    add_packet(0, 2, 8'h70, 1'b0);
    add_packet(2, 2, 8'h72, 1'b0);
    drain(4'b0101, 100, 0, 50, "t5");
    check("t5_first", 32'((tag_log.size() > 0) ? tag_log[0] : 8'h00), 32'hF0);
    check("t5_second", 32'((tag_log.size() > 1) ? tag_log[1] : 8'h00), 32'hF2);

    // Random traffic with valid gaps and backpressure.
    do_reset();
    for (int i = 0; i < N; i++) begin
      for (int p = 0; p < 4; p++) add_packet(i, $urandom_range(1, 4), 8'h00, 1'b1);
    end
    drain(4'b1111, 75, 20, 3000, "rand");

    // TAG_EN=0 instance: req1 single byte 5A.
    srst0 = 1'b0;
    nwr   = 0;
    bus0.req_valid = 4'b0010;
    bus0.req_data  = 32'h00005A00;
    bus0.req_last  = 4'b0010;
    #1;
    check("t6_idle_wr", 32'(bus0.tx_wr_en), 32'd0);
    check("t6_idle_gv", 32'(bus0.grant_valid), 32'd0);
    if (bus0.tx_wr_en) nwr++;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("t6_data_wr", 32'(bus0.tx_wr_en), 32'd1);
    check("t6_data_din", 32'(bus0.tx_din), 32'h5A);
    check("t6_data_rdy", 32'(bus0.req_ready), 32'b0010);
    check("t6_data_gid", 32'(bus0.grant_id), 32'd1);
    if (bus0.tx_wr_en) nwr++;
    @(posedge clk);
    @(negedge clk);
    bus0.req_valid = '0;
    bus0.req_last  = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (bus0.tx_wr_en) nwr++;
      @(posedge clk);
      @(negedge clk);
    end
    check("t6_writes", 32'(nwr), 32'd1);
    check("t6_end_gv", 32'(bus0.grant_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
